// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Four-port round-robin write arbiter feeding a simple FIFO.
//                An idle cycle picks a requester, starting the search at the
//                rotating pointer. That requester then holds the grant for up
//                to BURST writes. The grant also ends as soon as it drops its
//                request. A full FIFO stalls the burst in place.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int WIDTH = 32,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       ack,
    output logic             fifo_we,
    output logic [WIDTH-1:0] fifo_din,
    input  logic             fifo_full,
    output logic             grant_valid,
    output logic [1:0]       grant_id
);

    // burst_cnt value at which the current write is the last one of the grant
    localparam logic [3:0] c_last = 4'(BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_rr_ptr;
    logic [3:0]       r_burst_cnt;
    logic [1:0]       r_grant_id;

    logic             w_busy;
    logic             w_req_sel;
    logic             w_we;
    logic [WIDTH-1:0] w_din_sel;
    logic             w_pick_found;
    logic [1:0]       w_pick_id;
    logic [1:0]       w_scan_idx;

    assign w_busy      = (r_state == ST_BUSY);
    assign w_req_sel   = req[r_grant_id];
    assign w_we        = w_busy && w_req_sel && !fifo_full;

    assign fifo_we     = w_we;
    assign fifo_din    = w_busy ? w_din_sel : '0;
    assign grant_valid = w_busy;
    assign grant_id    = r_grant_id;

    // Round-robin search: first requesting port at rr_ptr, rr_ptr+1, ... (mod 4)
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = 2'd0;
        w_scan_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_scan_idx = r_rr_ptr + 2'(k);
            if (!w_pick_found && req[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_scan_idx;
            end
        end
    end

    // Data mux for the grant holder
    always_comb begin
        w_din_sel = din0;
        case (r_grant_id)
            2'd0:    w_din_sel = din0;
            2'd1:    w_din_sel = din1;
            2'd2:    w_din_sel = din2;
            default: w_din_sel = din3;
        endcase
    end

    // Only the grant holder is acked, and only when its word actually goes in
    always_comb begin
        ack = 4'b0000;
        if (w_we) begin
            ack[r_grant_id] = 1'b1;
        end
    end

    // Grant state machine: IDLE arbitrates, BUSY streams the holder's words
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= 2'd0;
            r_burst_cnt <= 4'd0;
            r_grant_id  <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_state     <= ST_BUSY;
                        r_grant_id  <= w_pick_id;
                        r_burst_cnt <= 4'd0;
                    end
                end
                ST_BUSY: begin
                    if (w_we) begin
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                    end
                    // A withdrawn request or the final burst write releases the
                    // grant; the pointer moves past the holder for fairness.
                    if (!w_req_sel || (w_we && (r_burst_cnt == c_last))) begin
                        r_state    <= ST_IDLE;
                        r_rr_ptr   <= r_grant_id + 2'd1;
                        r_grant_id <= 2'd0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Self-checking bench for fifo_wr_arbiter. Reference model
//                tracks grant holder / writes done / rotation pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] din [4];
    logic        fifo_full = 1'b0;

    logic [3:0]  ack;
    logic        fifo_we;
    logic [31:0] fifo_din;
    logic        grant_valid;
    logic [1:0]  grant_id;

    logic [3:0]  ack1;
    logic        fifo_we1;
    logic [31:0] fifo_din1;
    logic        grant_valid1;
    logic [1:0]  grant_id1;

    fifo_wr_arbiter #(.WIDTH(32), .BURST(4)) dut (
        .clk(clk), .reset(reset), .req(req),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .ack(ack), .fifo_we(fifo_we), .fifo_din(fifo_din), .fifo_full(fifo_full),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    fifo_wr_arbiter #(.WIDTH(32), .BURST(1)) dut1 (
        .clk(clk), .reset(reset), .req(req),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .ack(ack1), .fifo_we(fifo_we1), .fifo_din(fifo_din1), .fifo_full(fifo_full),
        .grant_valid(grant_valid1), .grant_id(grant_id1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
        int cyc;
    } wr_t;

    wr_t log0[$];
    wr_t log1[$];
    int  ncnt = 0;

    int  n_err = 0;
    int  n_chk = 0;

    // model of the BURST=4 instance: holder (-1 = none), writes done, pointer
    int  m_hold = -1;
    int  m_wr   = 0;
    int  m_ptr  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = -1;
        m_wr   = 0;
        m_ptr  = 0;
    endtask

    // One clock cycle: compare at negedge, log writes, advance model, then
    // return 1ns after the following posedge.
    task automatic tick();
        logic        e_we;
        logic [3:0]  e_ack;
        logic [31:0] e_din;
        logic        e_gv;
        logic [1:0]  e_gid;
        @(negedge clk);
        e_we  = 1'b0;
        e_ack = 4'b0000;
        e_din = 32'd0;
        e_gv  = 1'b0;
        e_gid = 2'd0;
        if (m_hold >= 0) begin
            e_gv  = 1'b1;
            e_gid = 2'(m_hold);
            e_we  = req[m_hold] && !fifo_full;
            e_ack = e_we ? (4'b0001 << m_hold) : 4'b0000;
            e_din = din[m_hold];
        end
        chk("fifo_we",     32'(fifo_we),     32'(e_we));
        chk("ack",         32'(ack),         32'(e_ack));
        chk("fifo_din",    fifo_din,         e_din);
        chk("grant_valid", 32'(grant_valid), 32'(e_gv));
        chk("grant_id",    32'(grant_id),    32'(e_gid));
        if (fifo_we)  log0.push_back('{int'(grant_id),  int'(fifo_din),  ncnt});
        if (fifo_we1) log1.push_back('{int'(grant_id1), int'(fifo_din1), ncnt});
        ncnt++;
        if (m_hold < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_hold < 0 && req[(m_ptr + k) % 4]) begin
                    m_hold = (m_ptr + k) % 4;
                end
            end
            m_wr = 0;
        end else if (!req[m_hold] || (e_we && (m_wr + 1 == 4))) begin
            m_ptr  = (m_hold + 1) % 4;
            m_hold = -1;
        end else if (e_we) begin
            m_wr++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        fifo_full = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst fifo_we",     32'(fifo_we),     32'd0);
        chk("rst ack",         32'(ack),         32'd0);
        chk("rst fifo_din",    fifo_din,         32'd0);
        chk("rst grant_valid", 32'(grant_valid), 32'd0);
        chk("rst grant_id",    32'(grant_id),    32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int b;
        int cb;
        for (int i = 0; i < 4; i++) din[i] = 32'd0;

        // ---- single requester, two bursts ----
        do_reset();
        b = log0.size(); cb = ncnt;
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            din[0] = 32'hA0 + 32'(log0.size() - b);
            tick();
        end
        chk("single count", 32'(log0.size() - b), 32'd8);
        if (log0.size() - b >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("single data", 32'(log0[b+i].data), 32'hA0 + 32'(i));
                chk("single cyc",  32'(log0[b+i].cyc - cb), (i < 4) ? 32'(i + 1) : 32'(i + 2));
            end
        end

        // ---- all four requesting: rotation 0,1,2,3 ----
        do_reset();
        b = log0.size(); cb = ncnt;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) din[i] = 32'h10 * 32'(i + 1);
        for (int c = 0; c < 20; c++) tick();
        chk("rotate count", 32'(log0.size() - b), 32'd16);
        if (log0.size() - b >= 16) begin
            for (int i = 0; i < 16; i++) begin
                chk("rotate id",  32'(log0[b+i].id), 32'(i / 4));
                chk("rotate cyc", 32'(log0[b+i].cyc - cb), 32'(i + i / 4 + 1));
            end
        end

        // ---- stall by fifo_full after the 2nd write ----
        do_reset();
        b = log0.size(); cb = ncnt;
        req = 4'b0010;
        for (int c = 0; c < 11; c++) begin
            fifo_full = (c >= 3 && c <= 7);
            din[1] = 32'hB0 + 32'(log0.size() - b);
            tick();
        end
        fifo_full = 1'b0;
        chk("stall count", 32'(log0.size() - b), 32'd4);
        if (log0.size() - b >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("stall id",   32'(log0[b+i].id), 32'd1);
                chk("stall data", 32'(log0[b+i].data), 32'hB0 + 32'(i));
                chk("stall cyc",  32'(log0[b+i].cyc - cb), (i < 2) ? 32'(i + 1) : 32'(i + 6));
            end
        end

        // ---- withdrawn request releases grant; pointer moves to 3 ----
        do_reset();
        b = log0.size(); cb = ncnt;
        din[0] = 32'hC0; din[2] = 32'hC2; din[3] = 32'hC3;
        req = 4'b0100; tick();
        req = 4'b1101; tick();
        req = 4'b1001; tick();
        tick();
        tick();
        chk("withdraw count", 32'(log0.size() - b), 32'd2);
        if (log0.size() - b >= 2) begin
            chk("withdraw id0",  32'(log0[b].id), 32'd2);
            chk("withdraw cyc0", 32'(log0[b].cyc - cb), 32'd1);
            chk("withdraw id1",  32'(log0[b+1].id), 32'd3);
            chk("withdraw cyc1", 32'(log0[b+1].cyc - cb), 32'd4);
            chk("withdraw dat1", 32'(log0[b+1].data), 32'hC3);
        end

        // ---- asynchronous reset in the middle of the 2nd write ----
        do_reset();
        req = 4'b0001;
        din[0] = 32'hD0;
        tick();
        tick();
        #1;
        chk("mid-rst pre we", 32'(fifo_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid-rst fifo_we",     32'(fifo_we),     32'd0);
        chk("mid-rst ack",         32'(ack),         32'd0);
        chk("mid-rst fifo_din",    fifo_din,         32'd0);
        chk("mid-rst grant_valid", 32'(grant_valid), 32'd0);
        chk("mid-rst grant_id",    32'(grant_id),    32'd0);
        model_reset();
        req = 4'b1100;
        #1;
        reset = 1'b0;
        tick();
        chk("post-rst grant_id",    32'(grant_id),    32'd2);
        chk("post-rst grant_valid", 32'(grant_valid), 32'd1);

        // ---- BURST=1 instance alternates between two requesters ----
        do_reset();
        b = log1.size(); cb = ncnt;
        req = 4'b0011;
        for (int c = 0; c < 8; c++) tick();
        chk("burst1 count", 32'(log1.size() - b), 32'd4);
        if (log1.size() - b >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("burst1 id",  32'(log1[b+i].id), 32'(i % 2));
                chk("burst1 cyc", 32'(log1[b+i].cyc - cb), 32'(2 * i + 1));
            end
        end

        // ---- randomized traffic against the model ----
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            fifo_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) din[i] = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
